// File: rtl/usb_pkt_encoder_if.sv
// Handshake bundle between the protocol FSM / line stage and the packet encoder.
interface usb_pkt_encoder_if;
    logic        encode;
    logic        kill;
    logic [3:0]  pid;
    logic [6:0]  addr;
    logic [3:0]  endp;
    logic [63:0] data;
    logic        bit_ready;
    logic        bit_out;
    logic        bit_valid;
    logic        eop;
    logic        pkt_sent;
    logic        busy;

    modport slave (
        input  encode, kill, pid, addr, endp, data, bit_ready,
        output bit_out, bit_valid, eop, pkt_sent, busy
    );

    modport master (
        output encode, kill, pid, addr, endp, data, bit_ready,
        input  bit_out, bit_valid, eop, pkt_sent, busy
    );
endinterface

// File: rtl/usb_pkt_encoder.sv
// USB transmit packet serializer: SYNC, PID, token/data fields and CRC as an LSB-first
// bit stream under ready/valid, then EOP. States: IDLE wait | SYNC 8 sync bits | PID pid byte
// | FIELD addr/endp or payload | CRC crc5/crc16 | EOP marker held to ready | DONE pkt_sent pulse.
module usb_pkt_encoder (
    input  logic              clk,
    input  logic              rst_b,
    usb_pkt_encoder_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_SYNC, S_PID, S_FIELD, S_CRC, S_EOP, S_DONE
    } state_t;

    state_t      r_state;
    logic [6:0]  r_cnt;
    logic [4:0]  r_crc5;
    logic [15:0] r_crc16;
    logic [3:0]  r_pid;
    logic [6:0]  r_addr;
    logic [3:0]  r_endp;
    logic [63:0] r_data;
    logic        r_bit_out;
    logic        r_bit_valid;
    logic        r_eop;
    logic        r_pkt_sent;
    logic        r_busy;

    logic        w_is_token;
    logic        w_is_data;
    logic        w_accept;
    logic [6:0]  w_cnt_inc;
    logic [4:0]  w_crc5_upd;
    logic [15:0] w_crc16_upd;
    state_t      w_nxt_state;
    logic [6:0]  w_nxt_cnt;
    logic [4:0]  w_c5;
    logic [15:0] w_c16;
    logic [1:0]  w_eidx;
    logic [2:0]  w_i5;
    logic [3:0]  w_i16;
    logic        w_nxt_bit;

    assign w_is_token  = (r_pid[1:0] == 2'b01);
    assign w_is_data   = (r_pid[1:0] == 2'b11);
    assign w_accept    = r_bit_valid & bus.bit_ready;
    assign w_cnt_inc   = r_cnt + 7'd1;
    assign w_crc5_upd  = {r_crc5[3:0], 1'b0} ^ ((r_bit_out ^ r_crc5[4]) ? 5'b00101 : 5'b00000);
    assign w_crc16_upd = {r_crc16[14:0], 1'b0} ^ ((r_bit_out ^ r_crc16[15]) ? 16'h8005 : 16'h0000);

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = w_cnt_inc;
        case (r_state)
            S_SYNC: if (r_cnt == 7'd7) begin
                w_nxt_state = S_PID;
                w_nxt_cnt   = 7'd0;
            end
            S_PID: if (r_cnt == 7'd7) begin
                w_nxt_state = (w_is_token || w_is_data) ? S_FIELD : S_EOP;
                w_nxt_cnt   = 7'd0;
            end
            S_FIELD: if (r_cnt == (w_is_token ? 7'd10 : 7'd63)) begin
                w_nxt_state = S_CRC;
                w_nxt_cnt   = 7'd0;
            end
            S_CRC: if (r_cnt == (w_is_token ? 7'd4 : 7'd15)) begin
                w_nxt_state = S_EOP;
                w_nxt_cnt   = 7'd0;
            end
            default: ;
        endcase
    end

    // The first CRC bit must reflect the field bit being accepted on the same edge.
    assign w_c5   = (r_state == S_FIELD) ? w_crc5_upd  : r_crc5;
    assign w_c16  = (r_state == S_FIELD) ? w_crc16_upd : r_crc16;
    assign w_eidx = w_nxt_cnt[1:0] + 2'd1;
    assign w_i5   = 3'd4 - w_nxt_cnt[2:0];
    assign w_i16  = 4'd15 - w_nxt_cnt[3:0];

    always_comb begin
        w_nxt_bit = 1'b0;
        case (w_nxt_state)
            S_SYNC:  w_nxt_bit = (w_nxt_cnt == 7'd7);
            S_PID:   w_nxt_bit = r_pid[w_nxt_cnt[1:0]] ^ w_nxt_cnt[2];
            S_FIELD: begin
                if (w_is_token)
                    w_nxt_bit = (w_nxt_cnt < 7'd7) ? r_addr[w_nxt_cnt[2:0]] : r_endp[w_eidx];
                else
                    w_nxt_bit = r_data[w_nxt_cnt[5:0]];
            end
            S_CRC:   w_nxt_bit = w_is_token ? ~w_c5[w_i5] : ~w_c16[w_i16];
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state     <= S_IDLE;
            r_cnt       <= 7'd0;
            r_crc5      <= 5'h1F;
            r_crc16     <= 16'hFFFF;
            r_pid       <= 4'd0;
            r_addr      <= 7'd0;
            r_endp      <= 4'd0;
            r_data      <= 64'd0;
            r_bit_out   <= 1'b0;
            r_bit_valid <= 1'b0;
            r_eop       <= 1'b0;
            r_pkt_sent  <= 1'b0;
            r_busy      <= 1'b0;
        end else if (bus.encode && (bus.kill || r_state == S_IDLE)) begin
            r_pid       <= bus.pid;
            r_addr      <= bus.addr;
            r_endp      <= bus.endp;
            r_data      <= bus.data;
            r_state     <= S_SYNC;
            r_cnt       <= 7'd0;
            r_crc5      <= 5'h1F;
            r_crc16     <= 16'hFFFF;
            r_bit_out   <= 1'b0;
            r_bit_valid <= 1'b1;
            r_eop       <= 1'b0;
            r_pkt_sent  <= 1'b0;
            r_busy      <= 1'b1;
        end else if (bus.kill) begin
            r_state     <= S_IDLE;
            r_cnt       <= 7'd0;
            r_crc5      <= 5'h1F;
            r_crc16     <= 16'hFFFF;
            r_bit_out   <= 1'b0;
            r_bit_valid <= 1'b0;
            r_eop       <= 1'b0;
            r_pkt_sent  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_SYNC, S_PID, S_FIELD, S_CRC: if (w_accept) begin
                    r_state <= w_nxt_state;
                    r_cnt   <= w_nxt_cnt;
                    if (r_state == S_FIELD && w_is_token) r_crc5  <= w_crc5_upd;
                    if (r_state == S_FIELD && w_is_data)  r_crc16 <= w_crc16_upd;
                    if (w_nxt_state == S_EOP) begin
                        r_bit_valid <= 1'b0;
                        r_eop       <= 1'b1;
                        r_bit_out   <= 1'b0;
                    end else begin
                        r_bit_out   <= w_nxt_bit;
                    end
                end
                S_EOP: if (bus.bit_ready) begin
                    r_state    <= S_DONE;
                    r_cnt      <= 7'd0;
                    r_eop      <= 1'b0;
                    r_pkt_sent <= 1'b1;
                end
                S_DONE: begin
                    r_state    <= S_IDLE;
                    r_cnt      <= 7'd0;
                    r_pkt_sent <= 1'b0;
                    r_busy     <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.bit_out   = r_bit_out;
    assign bus.bit_valid = r_bit_valid;
    assign bus.eop       = r_eop;
    assign bus.pkt_sent  = r_pkt_sent;
    assign bus.busy      = r_busy;
endmodule

// File: tb/tb_usb_pkt_encoder.sv
// Bench for usb_pkt_encoder: a bit-queue packet model checked on every accepted bit,
// plus literal timing/residual expectations for the directed packets.
module tb_usb_pkt_encoder;
    logic clk;
    logic rst_b;
    usb_pkt_encoder_if bus ();

    usb_pkt_encoder dut (.clk(clk), .rst_b(rst_b), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   errors = 0;
    int   checks = 0;
    logic exp_q[$];
    logic got_q[$];
    int   sent_cnt = 0;
    int   sent_base = 0;
    int   eop_cycles = 0;
    int   eop_base = 0;
    logic prev_hold = 1'b0;
    logic prev_bit = 1'b0;
    logic prev_kill = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] crc5_step(input logic [4:0] c, input logic d);
        return {c[3:0], 1'b0} ^ ((d ^ c[4]) ? 5'b00101 : 5'b00000);
    endfunction

    function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic d);
        return {c[14:0], 1'b0} ^ ((d ^ c[15]) ? 16'h8005 : 16'h0000);
    endfunction

    // Whole-packet model: the exact bit sequence the line stage must receive.
    task automatic load_expected(input logic [3:0] p, input logic [6:0] a,
                                 input logic [3:0] e, input logic [63:0] d);
        logic [4:0]  c5;
        logic [15:0] c16;
        logic        b;
        c5  = 5'h1F;
        c16 = 16'hFFFF;
        exp_q.delete();
        for (int i = 0; i < 7; i++) exp_q.push_back(1'b0);
        exp_q.push_back(1'b1);
        for (int i = 0; i < 4; i++) exp_q.push_back(p[i]);
        for (int i = 0; i < 4; i++) exp_q.push_back(~p[i]);
        if (p[1:0] == 2'b01) begin
            for (int i = 0; i < 11; i++) begin
                b = (i < 7) ? a[i] : e[i-7];
                exp_q.push_back(b);
                c5 = crc5_step(c5, b);
            end
            for (int i = 4; i >= 0; i--) exp_q.push_back(~c5[i]);
        end else if (p[1:0] == 2'b11) begin
            for (int i = 0; i < 64; i++) begin
                exp_q.push_back(d[i]);
                c16 = crc16_step(c16, d[i]);
            end
            for (int i = 15; i >= 0; i--) exp_q.push_back(~c16[i]);
        end
    endtask

    always @(negedge clk) begin
        if (rst_b) begin
            if (bus.bit_valid || bus.eop)
                check("valid_eop_exclusive", 64'(bus.bit_valid & bus.eop), 64'd0);
            if (prev_hold && !prev_kill) begin
                check("hold_valid", 64'(bus.bit_valid), 64'd1);
                check("hold_bit", 64'(bus.bit_out), 64'(prev_bit));
            end
            if (bus.bit_valid && bus.bit_ready) begin
                got_q.push_back(bus.bit_out);
                if (exp_q.size() == 0) begin
                    check("bit_overrun", 64'(exp_q.size()), 64'd1);
                end else begin
                    logic e;
                    e = exp_q.pop_front();
                    check($sformatf("bit%0d", got_q.size() - 1), 64'(bus.bit_out), 64'(e));
                end
            end
            if (bus.eop) eop_cycles++;
            if (bus.pkt_sent) sent_cnt++;
            prev_hold = bus.bit_valid && !bus.bit_ready;
            prev_bit  = bus.bit_out;
            prev_kill = bus.kill;
        end else begin
            prev_hold = 1'b0;
        end
    end

    // Encode edge happens inside; returns #1 after it with descriptor inputs scrambled.
    task automatic start_pkt(input logic [3:0] p, input logic [6:0] a,
                             input logic [3:0] e, input logic [63:0] d);
        load_expected(p, a, e, d);
        got_q.delete();
        sent_base = sent_cnt;
        eop_base  = eop_cycles;
        @(posedge clk); #1;
        bus.encode = 1'b1;
        bus.pid = p; bus.addr = a; bus.endp = e; bus.data = d;
        @(posedge clk); #1;
        bus.encode = 1'b0;
        bus.pid = ~p; bus.addr = ~a; bus.endp = ~e; bus.data = ~d;
    endtask

    task automatic wait_sent(input int budget, input bit tog);
        int n;
        n = 0;
        while (sent_cnt == sent_base && n < budget) begin
            @(posedge clk); #1;
            if (tog) bus.bit_ready = ~bus.bit_ready;
            n++;
        end
        check("sent_timeout", 64'(sent_cnt != sent_base), 64'd1);
        bus.bit_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("sent_once", 64'(sent_cnt - sent_base), 64'd1);
        check("all_bits_sent", 64'(exp_q.size()), 64'd0);
        check("idle_after", 64'(bus.busy), 64'd0);
    endtask

    task automatic check_res5(input string name);
        logic [4:0] c;
        c = 5'h1F;
        if (got_q.size() == 32) for (int i = 16; i < 32; i++) c = crc5_step(c, got_q[i]);
        check(name, 64'(c), 64'h0C);
    endtask

    task automatic check_res16(input string name);
        logic [15:0] c;
        c = 16'hFFFF;
        if (got_q.size() == 96) for (int i = 16; i < 96; i++) c = crc16_step(c, got_q[i]);
        check(name, 64'(c), 64'h800D);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ack_lit;
        ack_lit = 16'b0000_0001_0100_1011;
        rst_b = 1'b0;
        bus.encode = 1'b0; bus.kill = 1'b0; bus.bit_ready = 1'b1;
        bus.pid = 4'd0; bus.addr = 7'd0; bus.endp = 4'd0; bus.data = 64'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_outputs", 64'({bus.bit_out, bus.bit_valid, bus.eop, bus.pkt_sent, bus.busy}), 64'd0);
        @(negedge clk) rst_b = 1'b1;
        @(posedge clk); #1;
        check("idle_outputs", 64'({bus.bit_out, bus.bit_valid, bus.eop, bus.pkt_sent, bus.busy}), 64'd0);

        // ACK with literal cycle-by-cycle expectations
        start_pkt(4'b0010, 7'd0, 4'd0, 64'd0);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            check($sformatf("ack_bit%0d", k), 64'({bus.bit_valid, bus.bit_out}), 64'({1'b1, ack_lit[15-k]}));
        end
        @(negedge clk);
        check("ack_eop", 64'({bus.eop, bus.bit_valid, bus.pkt_sent}), 64'b100);
        @(negedge clk);
        check("ack_pkt_sent", 64'({bus.eop, bus.pkt_sent, bus.busy}), 64'b011);
        @(negedge clk);
        check("ack_busy_low", 64'({bus.pkt_sent, bus.busy}), 64'b00);
        check("ack_sent_once", 64'(sent_cnt - sent_base), 64'd1);

        // IN token, ready held high
        start_pkt(4'b1001, 7'h05, 4'h4, 64'd0);
        wait_sent(100, 1'b0);
        check("in_len", 64'(got_q.size()), 64'd32);
        check("in_eop_cycles", 64'(eop_cycles - eop_base), 64'd1);
        check_res5("in_crc5_residual");

        // DATA0 with toggling ready
        start_pkt(4'b0011, 7'd0, 4'd0, 64'h0123456789ABCDEF);
        wait_sent(400, 1'b1);
        check("data0_len", 64'(got_q.size()), 64'd96);
        check_res16("data0_crc16_residual");
        check("data0_byte0_lsb_first", 64'({got_q[23], got_q[22], got_q[21], got_q[20],
                                           got_q[19], got_q[18], got_q[17], got_q[16]}), 64'hEF);

        // DATA1 with EOP stalled for 10 cycles
        start_pkt(4'b1011, 7'd0, 4'd0, 64'hFEDCBA9876543210);
        repeat (96) @(posedge clk);
        #1 bus.bit_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check($sformatf("eop_hold%0d", k), 64'({bus.eop, bus.bit_valid, bus.pkt_sent}), 64'b100);
            @(posedge clk);
        end
        #1 bus.bit_ready = 1'b1;
        @(negedge clk);
        check("eop_before_accept", 64'({bus.eop, bus.pkt_sent}), 64'b10);
        @(posedge clk);
        @(negedge clk);
        check("sent_after_accept", 64'({bus.eop, bus.pkt_sent}), 64'b01);
        wait_sent(10, 1'b0);
        check_res16("data1_crc16_residual");

        // encode while busy without kill is ignored
        start_pkt(4'b1011, 7'd0, 4'd0, 64'h5A5A_0F0F_C3C3_9696);
        repeat (20) @(posedge clk);
        #1;
        bus.encode = 1'b1; bus.pid = 4'b0010; bus.data = 64'h1111_2222_3333_4444;
        @(posedge clk); #1;
        bus.encode = 1'b0;
        wait_sent(200, 1'b0);
        check("busy_encode_len", 64'(got_q.size()), 64'd96);
        check_res16("busy_encode_crc16_residual");

        // kill at bit 40 of a data packet
        start_pkt(4'b0011, 7'd0, 4'd0, 64'hDEAD_BEEF_0BAD_F00D);
        repeat (40) @(posedge clk);
        #1 bus.kill = 1'b1;
        @(posedge clk); #1;
        bus.kill = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("kill_outputs", 64'({bus.bit_valid, bus.eop, bus.busy, bus.pkt_sent}), 64'd0);
        repeat (120) @(posedge clk);
        #1;
        check("kill_no_sent", 64'(sent_cnt - sent_base), 64'd0);
        check("kill_bits_before_abort", 64'(got_q.size()), 64'd41);

        // kill+encode restart into NAK mid-token
        start_pkt(4'b0001, 7'h3A, 4'h7, 64'd0);
        repeat (20) @(posedge clk);
        #1;
        bus.kill = 1'b1; bus.encode = 1'b1; bus.pid = 4'b1010;
        @(posedge clk); #1;
        bus.kill = 1'b0; bus.encode = 1'b0; bus.pid = 4'b0101;
        load_expected(4'b1010, 7'd0, 4'd0, 64'd0);
        got_q.delete();
        wait_sent(50, 1'b0);
        check("nak_len", 64'(got_q.size()), 64'd16);

        // asynchronous reset mid-packet, then recovery
        start_pkt(4'b1101, 7'h7F, 4'hF, 64'd0);
        repeat (10) @(posedge clk);
        #2 rst_b = 1'b0;
        #1;
        check("async_rst_outputs", 64'({bus.bit_out, bus.bit_valid, bus.eop, bus.pkt_sent, bus.busy}), 64'd0);
        exp_q.delete();
        @(negedge clk) rst_b = 1'b1;
        check("rst_no_sent", 64'(sent_cnt - sent_base), 64'd0);
        start_pkt(4'b1101, 7'h7F, 4'hF, 64'd0);
        wait_sent(100, 1'b0);
        check("setup_len", 64'(got_q.size()), 64'd32);
        check_res5("setup_crc5_residual");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
